// File: rtl/fetch_pc_unit.sv
// Fetch PC generator with BTB-driven next-PC, in-order prediction queue and mispredict redirect.
// Optional build macro FETCH_BP_STATS_EN adds saturating branch/mispredict counters.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned QUEUE_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        stall,
  input  logic        ihit,
  output logic        imem_ren,
  output logic [31:0] imem_addr,
  output logic [31:0] bp_pc,
  input  logic        bp_predicted_outcome,
  input  logic [31:0] bp_predicted_target,
  output logic [31:0] bp_update_pc,
  output logic        bp_update_btb,
  output logic        bp_branch_outcome,
  output logic [31:0] bp_branch_target,
  output logic        fetch_valid,
  output logic [31:0] fetch_pc,
  output logic        fetch_pred_taken,
  input  logic        ex_resolve_valid,
  input  logic        ex_is_branch,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
`ifdef FETCH_BP_STATS_EN
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts,
`endif
  output logic        flush,
  output logic        queue_full
);

  localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QUEUE_DEPTH);

  logic [31:0]      pc_q, pc_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             flush_q;

  logic [31:0] q_pc     [QUEUE_DEPTH];
  logic        q_taken  [QUEUE_DEPTH];
  logic [31:0] q_target [QUEUE_DEPTH];

  logic        upd_q;
  logic [31:0] upd_pc_q, upd_target_q;
  logic        upd_outcome_q;
  logic        upd_d;

  logic        issue, resolve, mispredict, push, pop;
  logic [31:0] head_pc, head_target, head_seq, actual_next, pred_next;
  logic        head_taken;

  assign queue_full = (count_q == FULL_CNT);
  assign imem_ren   = !stall && !queue_full && !flush_q;
  assign imem_addr  = pc_q;
  assign bp_pc      = pc_q;
  assign flush      = flush_q;

  assign issue   = imem_ren && ihit;
  assign resolve = ex_resolve_valid && (count_q != '0);

  assign head_pc     = q_pc[rd_ptr_q];
  assign head_taken  = q_taken[rd_ptr_q];
  assign head_target = q_target[rd_ptr_q];
  assign head_seq    = head_pc + 32'd4;
  assign actual_next = (ex_is_branch && ex_taken) ? ex_target : head_seq;
  assign pred_next   = head_taken ? head_target : head_seq;
  assign mispredict  = resolve && (actual_next != pred_next);

  // A mispredict squashes the same-cycle issue: it is shown to decode but never enqueued.
  assign push = issue && !mispredict;
  assign pop  = resolve && !mispredict;

  // Aliasing (predicted taken on a non-branch) also retrains the BTB.
  assign upd_d = resolve && (ex_is_branch || head_taken);

  assign fetch_valid      = issue;
  assign fetch_pc         = issue ? pc_q : 32'h0;
  assign fetch_pred_taken = issue && bp_predicted_outcome;

  assign bp_update_btb     = upd_q;
  assign bp_update_pc      = upd_pc_q;
  assign bp_branch_outcome = upd_outcome_q;
  assign bp_branch_target  = upd_target_q;

  always_comb begin
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (mispredict) begin
      pc_d     = actual_next;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (issue) begin
        pc_d = bp_predicted_outcome ? bp_predicted_target : pc_q + 32'd4;
      end
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pc_q          <= RESET_PC;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      flush_q       <= 1'b0;
      upd_q         <= 1'b0;
      upd_pc_q      <= 32'h0;
      upd_outcome_q <= 1'b0;
      upd_target_q  <= 32'h0;
    end else begin
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      flush_q  <= mispredict;
      upd_q    <= upd_d;
      if (upd_d) begin
        upd_pc_q      <= head_pc;
        upd_outcome_q <= ex_is_branch && ex_taken;
        upd_target_q  <= ex_target;
      end
    end
  end

  // Entry storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge CLK) begin
    if (push) begin
      q_pc[wr_ptr_q]     <= pc_q;
      q_taken[wr_ptr_q]  <= bp_predicted_outcome;
      q_target[wr_ptr_q] <= bp_predicted_target;
    end
  end

`ifdef FETCH_BP_STATS_EN
  logic [31:0] stat_br_q, stat_mp_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stat_br_q <= 32'h0;
      stat_mp_q <= 32'h0;
    end else begin
      if (resolve && ex_is_branch && (stat_br_q != 32'hFFFF_FFFF)) begin
        stat_br_q <= stat_br_q + 32'd1;
      end
      if (mispredict && (stat_mp_q != 32'hFFFF_FFFF)) begin
        stat_mp_q <= stat_mp_q + 32'd1;
      end
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: directed stimulus pushes expected fetch/update/flush
// events into queues that a negedge monitor pops and compares.
module tb_fetch_pc_unit;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        stall = 1'b1;
  logic        ihit = 1'b1;
  logic        imem_ren;
  logic [31:0] imem_addr, bp_pc;
  logic        bp_predicted_outcome;
  logic [31:0] bp_predicted_target;
  logic [31:0] bp_update_pc;
  logic        bp_update_btb, bp_branch_outcome;
  logic [31:0] bp_branch_target;
  logic        fetch_valid, fetch_pred_taken;
  logic [31:0] fetch_pc;
  logic        ex_resolve_valid = 1'b0;
  logic        ex_is_branch = 1'b0;
  logic        ex_taken = 1'b0;
  logic [31:0] ex_target = 32'h0;
  logic        flush, queue_full;
`ifdef FETCH_BP_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts;
`endif

  fetch_pc_unit #(
    .RESET_PC   (32'h0000_0100),
    .QUEUE_DEPTH(4)
  ) dut (
    .CLK                 (CLK),
    .nRST                (nRST),
    .stall               (stall),
    .ihit                (ihit),
    .imem_ren            (imem_ren),
    .imem_addr           (imem_addr),
    .bp_pc               (bp_pc),
    .bp_predicted_outcome(bp_predicted_outcome),
    .bp_predicted_target (bp_predicted_target),
    .bp_update_pc        (bp_update_pc),
    .bp_update_btb       (bp_update_btb),
    .bp_branch_outcome   (bp_branch_outcome),
    .bp_branch_target    (bp_branch_target),
    .fetch_valid         (fetch_valid),
    .fetch_pc            (fetch_pc),
    .fetch_pred_taken    (fetch_pred_taken),
    .ex_resolve_valid    (ex_resolve_valid),
    .ex_is_branch        (ex_is_branch),
    .ex_taken            (ex_taken),
    .ex_target           (ex_target),
`ifdef FETCH_BP_STATS_EN
    .stat_branches       (stat_branches),
    .stat_mispredicts    (stat_mispredicts),
`endif
    .flush               (flush),
    .queue_full          (queue_full)
  );

  always #5 CLK = ~CLK;

  // Tiny BTB: 0x200 -> 0x400 (real branch), 0x600 -> 0x700 (aliased non-branch).
  always_comb begin
    bp_predicted_outcome = 1'b0;
    bp_predicted_target  = 32'h0;
    if (bp_pc == 32'h0000_0200) begin
      bp_predicted_outcome = 1'b1;
      bp_predicted_target  = 32'h0000_0400;
    end else if (bp_pc == 32'h0000_0600) begin
      bp_predicted_outcome = 1'b1;
      bp_predicted_target  = 32'h0000_0700;
    end
  end

  typedef struct {
    logic [31:0] pc;
    logic        taken;
  } fetch_t;

  typedef struct {
    logic [31:0] pc;
    logic        outcome;
    logic [31:0] target;
  } upd_t;

  fetch_t      fetch_exp[$];
  upd_t        upd_exp[$];
  logic [31:0] flush_exp[$];

  int  checks = 0;
  int  errors = 0;
  logic mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got event with value %h, required no event", name, act);
  endtask

  always @(negedge CLK) begin
    if (mon_en) begin
      if (fetch_valid) begin
        if (fetch_exp.size() == 0) begin
          unexpected("fetch", fetch_pc);
        end else begin
          fetch_t f;
          f = fetch_exp.pop_front();
          check("fetch_pc", fetch_pc, f.pc);
          check("fetch_pred_taken", 32'(fetch_pred_taken), 32'(f.taken));
        end
      end
      if (bp_update_btb) begin
        if (upd_exp.size() == 0) begin
          unexpected("bp_update", bp_update_pc);
        end else begin
          upd_t u;
          u = upd_exp.pop_front();
          check("bp_update_pc", bp_update_pc, u.pc);
          check("bp_branch_outcome", 32'(bp_branch_outcome), 32'(u.outcome));
          check("bp_branch_target", bp_branch_target, u.target);
        end
      end
      if (flush) begin
        if (flush_exp.size() == 0) begin
          unexpected("flush", imem_addr);
        end else begin
          check("flush_redirect_pc", imem_addr, flush_exp.pop_front());
          check("flush_imem_ren", 32'(imem_ren), 32'h0);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic exp_fetch(input logic [31:0] pc, input logic taken);
    fetch_t f;
    f.pc    = pc;
    f.taken = taken;
    fetch_exp.push_back(f);
  endtask

  task automatic exp_upd(input logic [31:0] pc, input logic outcome, input logic [31:0] target);
    upd_t u;
    u.pc      = pc;
    u.outcome = outcome;
    u.target  = target;
    upd_exp.push_back(u);
  endtask

  task automatic issue_one(input logic [31:0] pc, input logic taken);
    exp_fetch(pc, taken);
    stall = 1'b0;
    cyc();
    stall = 1'b1;
  endtask

  task automatic drive_resolve(input logic br, input logic tk, input logic [31:0] tgt);
    ex_resolve_valid = 1'b1;
    ex_is_branch     = br;
    ex_taken         = tk;
    ex_target        = tgt;
  endtask

  task automatic clear_resolve();
    ex_resolve_valid = 1'b0;
    ex_is_branch     = 1'b0;
    ex_taken         = 1'b0;
    ex_target        = 32'h0;
  endtask

  // Resolve cycle plus one trailing cycle so the flush/update strobe is observed.
  task automatic resolve(input logic br, input logic tk, input logic [31:0] tgt);
    drive_resolve(br, tk, tgt);
    cyc();
    clear_resolve();
    cyc();
  endtask

  task automatic issue_resolve(input logic [31:0] pc, input logic br, input logic tk,
                               input logic [31:0] tgt);
    exp_fetch(pc, 1'b0);
    stall = 1'b0;
    drive_resolve(br, tk, tgt);
    cyc();
    stall = 1'b1;
    clear_resolve();
    cyc();
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    check("rst_imem_addr", imem_addr, 32'h100);
    check("rst_bp_pc", bp_pc, 32'h100);
    check("rst_flush", 32'(flush), 32'h0);
    check("rst_update", 32'(bp_update_btb), 32'h0);
    check("rst_update_pc", bp_update_pc, 32'h0);
    check("rst_queue_full", 32'(queue_full), 32'h0);
    check("rst_fetch_valid", 32'(fetch_valid), 32'h0);
    nRST = 1'b1;
    cyc();
    mon_en = 1'b1;

    // Sequential fetch from RESET_PC
    exp_fetch(32'h100, 1'b0);
    exp_fetch(32'h104, 1'b0);
    exp_fetch(32'h108, 1'b0);
    stall = 1'b0;
    repeat (3) cyc();
    stall = 1'b1;
    check("seq_next_pc", imem_addr, 32'h10C);
    repeat (3) resolve(1'b0, 1'b0, 32'h0);

    // Mispredict redirect to 0x200
    issue_one(32'h10C, 1'b0);
    exp_upd(32'h10C, 1'b1, 32'h200);
    flush_exp.push_back(32'h200);
    resolve(1'b1, 1'b1, 32'h200);
    check("redirect_200", imem_addr, 32'h200);

    // Correct taken prediction at 0x200
    issue_one(32'h200, 1'b1);
    check("pred_taken_pc", imem_addr, 32'h400);
    exp_upd(32'h200, 1'b1, 32'h400);
    resolve(1'b1, 1'b1, 32'h400);

    // Predicted not-taken at 0x300, actually taken to 0x500
    issue_one(32'h400, 1'b0);
    exp_upd(32'h400, 1'b1, 32'h300);
    flush_exp.push_back(32'h300);
    resolve(1'b1, 1'b1, 32'h300);
    issue_one(32'h300, 1'b0);
    exp_upd(32'h300, 1'b1, 32'h500);
    flush_exp.push_back(32'h500);
    resolve(1'b1, 1'b1, 32'h500);
    check("nt_mispredict_pc", imem_addr, 32'h500);
    check("nt_queue_empty", 32'(queue_full), 32'h0);

    // Fill the queue, then one resolve frees a slot
    exp_fetch(32'h500, 1'b0);
    exp_fetch(32'h504, 1'b0);
    exp_fetch(32'h508, 1'b0);
    exp_fetch(32'h50C, 1'b0);
    stall = 1'b0;
    repeat (4) cyc();
    check("full_flag", 32'(queue_full), 32'h1);
    check("full_imem_ren", 32'(imem_ren), 32'h0);
    cyc();
    exp_fetch(32'h510, 1'b0);
    resolve(1'b0, 1'b0, 32'h0);
    stall = 1'b1;
    check("refill_full", 32'(queue_full), 32'h1);
    check("refill_pc", imem_addr, 32'h514);

    // Push and pop in one cycle keeps the count; one more push fills it
    resolve(1'b0, 1'b0, 32'h0);
    issue_resolve(32'h514, 1'b0, 1'b0, 32'h0);
    check("pushpop_not_full", 32'(queue_full), 32'h0);
    issue_one(32'h518, 1'b0);
    check("pushpop_full", 32'(queue_full), 32'h1);
    repeat (4) resolve(1'b0, 1'b0, 32'h0);
    check("drain_not_full", 32'(queue_full), 32'h0);
    resolve(1'b1, 1'b1, 32'h999);

    // Aliasing: BTB says taken at non-branch 0x600
    issue_one(32'h51C, 1'b0);
    exp_upd(32'h51C, 1'b1, 32'h600);
    flush_exp.push_back(32'h600);
    resolve(1'b1, 1'b1, 32'h600);
    issue_one(32'h600, 1'b1);
    check("alias_pred_pc", imem_addr, 32'h700);
    exp_upd(32'h600, 1'b0, 32'h123);
    flush_exp.push_back(32'h604);
    resolve(1'b0, 1'b0, 32'h123);
    check("alias_redirect", imem_addr, 32'h604);

    // Mispredict resolve in the same cycle as an issue
    issue_one(32'h604, 1'b0);
    exp_upd(32'h604, 1'b1, 32'h800);
    flush_exp.push_back(32'h800);
    issue_resolve(32'h608, 1'b1, 1'b1, 32'h800);
    check("sim_mispredict_pc", imem_addr, 32'h800);
    issue_one(32'h800, 1'b0);
    exp_upd(32'h800, 1'b1, 32'h900);
    flush_exp.push_back(32'h900);
    resolve(1'b1, 1'b1, 32'h900);

    // 32-bit wrap of the sequential PC
    issue_one(32'h900, 1'b0);
    exp_upd(32'h900, 1'b1, 32'hFFFF_FFFC);
    flush_exp.push_back(32'hFFFF_FFFC);
    resolve(1'b1, 1'b1, 32'hFFFF_FFFC);
    issue_one(32'hFFFF_FFFC, 1'b0);
    check("pc_wrap", imem_addr, 32'h0);
    resolve(1'b0, 1'b0, 32'h0);

    // Reset mid-operation clears pending flush/update and the queue
    issue_one(32'h0, 1'b0);
    mon_en = 1'b0;
    drive_resolve(1'b1, 1'b1, 32'h40);
    cyc();
    clear_resolve();
    nRST = 1'b0;
    #1;
    check("midrst_flush", 32'(flush), 32'h0);
    check("midrst_update", 32'(bp_update_btb), 32'h0);
    check("midrst_pc", imem_addr, 32'h100);
    check("midrst_full", 32'(queue_full), 32'h0);
    cyc();
    nRST = 1'b1;
    cyc();
    mon_en = 1'b1;
    resolve(1'b1, 1'b1, 32'h40);
    repeat (2) cyc();

    check("fetch_leftover", 32'(fetch_exp.size()), 32'h0);
    check("update_leftover", 32'(upd_exp.size()), 32'h0);
    check("flush_leftover", 32'(flush_exp.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Fetch-side PC generator that sits directly upstream of the branch predictor/BTB.
- Each cycle it drives the current PC to the BTB lookup, issues the instruction memory read, and picks the next PC from the BTB prediction.
- It holds an in-order queue of in-flight predictions and checks each one against the execute-stage resolution.
- On a mispredict it redirects fetch, flushes the pipeline, and drives the BTB update.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
QUEUE_DEPTH, 4, in-flight prediction entries (power of 2, >=2).

Ports:
CLK  in  1  clock, rising edge.
nRST  in  1  asynchronous active-low reset.
stall  in  1  hold fetch; no new issue.
ihit  in  1  instruction memory accepted the current imem_addr this cycle.
imem_ren  out  1  fetch request.
imem_addr  out  32  fetch address (= pc register).
bp_pc  out  32  BTB lookup PC (= pc register).
bp_predicted_outcome  in  1  BTB predicts taken (combinational from bp_pc).
bp_predicted_target  in  32  BTB predicted target.
bp_update_pc  out  32  PC of the resolved branch.
bp_update_btb  out  1  one-cycle BTB write strobe.
bp_branch_outcome  out  1  actual taken.
bp_branch_target  out  32  actual target.
fetch_valid  out  1  fetched instruction handed to decode this cycle.
fetch_pc  out  32  PC of the fetched instruction.
fetch_pred_taken  out  1  prediction carried with the instruction.
ex_resolve_valid  in  1  execute retires the oldest in-flight instruction.
ex_is_branch  in  1  that instruction is a branch or jump.
ex_taken  in  1  actual taken.
ex_target  in  32  actual target.
flush  out  1  squash all younger pipeline state.
queue_full  out  1  prediction queue full.

Behaviour:
- Reset (async, nRST low): pc=RESET_PC, queue empty. All outputs 0 except imem_addr/bp_pc=RESET_PC; these are combinational from pc.
- imem_ren = !stall && !queue_full && !flush.
- Issue occurs when imem_ren && ihit.
- On issue:
  - push {pc, bp_predicted_outcome, bp_predicted_target}.
  - pc <= bp_predicted_outcome ? bp_predicted_target : pc+4.
  - fetch_valid, fetch_pc and fetch_pred_taken are combinational the same cycle.
- Resolution (ex_resolve_valid && queue not empty):
  - Pop the head.
  - actual_next = (ex_is_branch && ex_taken) ? ex_target : head.pc+4.
  - pred_next = head.pred_taken ? head.pred_target : head.pc+4.
  - mispredict = actual_next != pred_next.
- Mispredict, at the next edge:
  - pc <= actual_next.
  - queue cleared (the popped entry and all younger entries).
  - flush registered high for exactly 1 cycle.
  - No issue occurs in the flush cycle.
- Simultaneous issue and mispredict resolve: the mispredict wins. The issued instruction is not enqueued, pc takes actual_next, and fetch_valid is still shown that cycle; decode discards it via the following flush.
- Simultaneous issue and correct resolve: push and pop in the same cycle; count unchanged. A full queue accepts no push regardless of pop (imem_ren already low).
- BTB update, registered, 1 cycle after resolve:
  - Fires when ex_is_branch, OR when the head predicted taken but the instruction is not a branch (aliasing).
  - bp_update_btb=1 for 1 cycle; bp_update_pc=head.pc; bp_branch_outcome = ex_is_branch & ex_taken; bp_branch_target=ex_target.
  - The update is independent of the mispredict decision.
- ex_resolve_valid with an empty queue: ignored; no pop, no update, no flush.
- Queue pointers wrap modulo QUEUE_DEPTH. Count is 0..QUEUE_DEPTH; queue_full = (count==QUEUE_DEPTH).
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC+4 = 0.
- stall with ihit high: no issue, pc holds. Reset asserted mid-operation clears the queue and any pending update/flush immediately.

Optional Feature:
- Macro: FETCH_BP_STATS_EN.
- Defined:
  - Adds outputs stat_branches[31:0] and stat_mispredicts[31:0].
  - Both reset to 0 and increment on each resolved branch and each mispredict respectively.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset with RESET_PC=0x100, no stall, ihit=1, BTB never taken -> imem_addr 0x100, 0x104, 0x108 on consecutive cycles; fetch_valid=1 each cycle.
- At pc 0x200 BTB predicts taken to 0x400 -> next imem_addr=0x400. Resolve ex_is_branch=1, taken, target 0x400 -> no flush; bp_update_btb pulses 1 cycle later with update_pc=0x200, outcome=1.
- Predicted not-taken at 0x300; resolve taken to 0x500 -> flush high 1 cycle, next imem_addr=0x500, queue empty, bp_update_btb with outcome=1, target=0x500.
- Hold ex_resolve_valid=0 with ihit=1 -> after QUEUE_DEPTH (4) issues queue_full=1 and imem_ren=0. One resolve -> issue resumes the next cycle.
- Aliasing: BTB predicts taken at a non-branch 0x600; resolve ex_is_branch=0 -> flush, pc=0x604, bp_update_btb with outcome=0.
- Mispredict resolve in the same cycle as an ihit issue -> issued PC not enqueued, pc=actual_next. Also: ex_resolve_valid on an empty queue -> no flush, no update.
